// File: rtl/gpio_config_loader_if.sv
// Pad-side bus for the GPIO configuration loader: serial chain in/out,
// commit/restore requests, and the committed configuration word.
interface gpio_config_loader_if #(
    parameter int CFG_WIDTH = 10
);
    logic [CFG_WIDTH-1:0] gpio_defaults;
    logic                 shift_valid;
    logic                 shift_data;
    logic                 load;
    logic                 restore;
    logic                 shift_data_out;
    logic [CFG_WIDTH-1:0] gpio_config;
    logic                 load_done;
    logic                 load_error;
    logic                 busy;

    modport master (
        output gpio_defaults, shift_valid, shift_data, load, restore,
        input  shift_data_out, gpio_config, load_done, load_error, busy
    );

    modport slave (
        input  gpio_defaults, shift_valid, shift_data, load, restore,
        output shift_data_out, gpio_config, load_done, load_error, busy
    );
endinterface

// File: rtl/gpio_config_loader.sv
// Serial GPIO configuration loader: MSB-first shift chain, a commit that is only
// accepted once a full word has been shifted in, and restore-to-defaults.
module gpio_config_loader #(
    parameter int CFG_WIDTH = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    gpio_config_loader_if.slave  bus
);
    localparam int CW = $clog2(CFG_WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CFG_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFTING, ARMED} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [CFG_WIDTH-1:0] sr;
    logic [CFG_WIDTH-1:0] gpio_config;
    logic                 load_done;
    logic                 load_error;
    logic                 busy;

    // state mirrors cnt: IDLE at 0, ARMED once cnt has saturated at CFG_WIDTH
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            sr          <= bus.gpio_defaults;
            gpio_config <= bus.gpio_defaults;
            load_done   <= 1'b0;
            load_error  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            load_done  <= 1'b0;
            load_error <= 1'b0;
            if (bus.restore) begin
                state       <= IDLE;
                cnt         <= '0;
                sr          <= bus.gpio_defaults;
                gpio_config <= bus.gpio_defaults;
                busy        <= 1'b0;
            end else if (bus.load) begin
                state <= IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
                if (state == ARMED) begin
                    gpio_config <= sr;
                    load_done   <= 1'b1;
                end else begin
                    load_error  <= 1'b1;
                end
            end else if (bus.shift_valid) begin
                sr <= {sr[CFG_WIDTH-2:0], bus.shift_data};
                // once armed the counter holds; the chain keeps passing data through
                if (state != ARMED) begin
                    cnt   <= cnt + 1'b1;
                    busy  <= 1'b1;
                    state <= (cnt == CNT_LAST) ? ARMED : SHIFTING;
                end
            end
        end
    end

    assign bus.shift_data_out = sr[CFG_WIDTH-1];
    assign bus.gpio_config    = gpio_config;
    assign bus.load_done      = load_done;
    assign bus.load_error     = load_error;
    assign bus.busy           = busy;
endmodule

// File: tb/tb_gpio_config_loader.sv
// Directed bench for gpio_config_loader: expected outputs queued per step,
// serial chain output checked against a bit-queue delay line.
module tb_gpio_config_loader;
    localparam int W = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    gpio_config_loader_if #(.CFG_WIDTH(W)) bus ();

    gpio_config_loader #(.CFG_WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string        tag;
        logic [W-1:0] cfg;
        logic         done;
        logic         err;
        logic         busy;
    } exp_t;

    exp_t sb[$];
    logic chain[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chain_reload();
        chain.delete();
        for (int i = W - 1; i >= 0; i--) chain.push_back(bus.gpio_defaults[i]);
    endtask

    // drive one cycle of stimulus at negedge, compare the registered result at the next negedge
    task automatic step(input logic sv, input logic sd, input logic ld, input logic rs,
                        input logic rst, input string tag, input logic [W-1:0] cfg,
                        input logic done, input logic err, input logic bsy);
        exp_t e;
        bus.shift_valid = sv;
        bus.shift_data  = sd;
        bus.load        = ld;
        bus.restore     = rs;
        reset           = rst;
        sb.push_back('{tag, cfg, done, err, bsy});
        @(posedge clock);
        @(negedge clock);
        bus.shift_valid = 1'b0;
        bus.shift_data  = 1'b0;
        bus.load        = 1'b0;
        bus.restore     = 1'b0;
        reset           = 1'b0;
        if (rst || rs) chain_reload();
        else if (!ld && sv) begin
            void'(chain.pop_front());
            chain.push_back(sd);
        end
        e = sb.pop_front();
        chk({e.tag, ".cfg"},  32'(bus.gpio_config), 32'(e.cfg));
        chk({e.tag, ".done"}, 32'(bus.load_done),   32'(e.done));
        chk({e.tag, ".err"},  32'(bus.load_error),  32'(e.err));
        chk({e.tag, ".busy"}, 32'(bus.busy),        32'(e.busy));
        chk({e.tag, ".sdo"},  32'(bus.shift_data_out), 32'(chain[0]));
    endtask

    task automatic shift_bits(input logic [31:0] w, input int n, input string tag,
                              input logic [W-1:0] cfg);
        for (int i = n - 1; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b0, 1'b0, tag, cfg, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [24:0] p;
        logic [W-1:0] p_tail;
        p = 25'h16BC539;
        p_tail = p[W-1:0];
        bus.gpio_defaults = 10'h007;
        bus.shift_valid = 1'b0;
        bus.shift_data  = 1'b0;
        bus.load        = 1'b0;
        bus.restore     = 1'b0;
        chain_reload();
        @(negedge clock);

        step(0, 0, 0, 0, 1, "rst0", 10'h007, 0, 0, 0);
        step(0, 0, 0, 0, 1, "rst1", 10'h007, 0, 0, 0);
        step(0, 1, 0, 0, 0, "ign_sd", 10'h007, 0, 0, 0);
        // load and shift together in IDLE: load wins, shift is dropped
        step(1, 1, 1, 0, 0, "ld_idle", 10'h007, 0, 1, 0);
        step(0, 0, 0, 0, 0, "ld_idle_clr", 10'h007, 0, 0, 0);

        shift_bits(32'hB, 4, "sh4", 10'h007);
        step(0, 0, 1, 0, 0, "ld_short", 10'h007, 0, 1, 0);
        step(0, 0, 0, 0, 0, "ld_short_clr", 10'h007, 0, 0, 0);

        shift_bits(32'h3A5, 10, "sh3a5", 10'h007);
        step(0, 0, 1, 0, 0, "ld_3a5", 10'h3A5, 1, 0, 0);
        step(0, 0, 0, 0, 0, "ld_3a5_clr", 10'h3A5, 0, 0, 0);

        shift_bits(32'(p), 25, "shp", 10'h3A5);
        step(0, 0, 1, 0, 0, "ld_p", p_tail, 1, 0, 0);

        step(0, 0, 0, 1, 0, "restore", 10'h007, 0, 0, 0);
        shift_bits(32'h3A5, 10, "sh_arm", 10'h007);
        step(0, 0, 1, 1, 0, "rs_ld", 10'h007, 0, 0, 0);
        step(0, 0, 0, 0, 0, "rs_ld_clr", 10'h007, 0, 0, 0);
        // chain output here replays the restored defaults
        shift_bits(32'h2C6, 10, "sh_2c6", 10'h007);
        step(0, 0, 1, 0, 0, "ld_2c6", 10'h2C6, 1, 0, 0);

        shift_bits(32'h2A, 6, "sh6", 10'h2C6);
        step(0, 0, 0, 0, 1, "rst_mid", 10'h007, 0, 0, 0);
        step(0, 0, 1, 0, 0, "ld_after_rst", 10'h007, 0, 1, 0);
        step(0, 0, 0, 0, 0, "ld_after_rst_clr", 10'h007, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/gpio_config_loader.md
GPIO_CONFIG_LOADER -- requirements
Module: gpio_config_loader

Interface
REQ-001: Parameter CFG_WIDTH, default 10, SHALL be the width of the GPIO configuration word.
REQ-002: The block SHALL have one clock; reset is synchronous and active-high.
REQ-003: clock  input  1  sole clock; all state changes on the rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: gpio_defaults  input  CFG_WIDTH  static default word driven by the per-pad defaults block.
REQ-006: shift_valid  input  1  qualifies one serial bit on shift_data this cycle.
REQ-007: shift_data  input  1  serial configuration bit, MSB-first.
REQ-008: load  input  1  single-cycle request to commit the shift register to gpio_config.
REQ-009: restore  input  1  single-cycle request to reapply gpio_defaults.
REQ-010: shift_data_out  output  1  serial chain output to the next pad; equals sr[CFG_WIDTH-1].
REQ-011: gpio_config  output  CFG_WIDTH  active pad configuration word, registered.
REQ-012: load_done  output  1  one-cycle pulse: commit succeeded.
REQ-013: load_error  output  1  one-cycle pulse: commit rejected.
REQ-014: busy  output  1  high while the bit count is non-zero.

Function
REQ-015: Shift register sr[CFG_WIDTH-1:0]: on an accepted shift, sr SHALL become {sr[CFG_WIDTH-2:0], shift_data}.
REQ-016: shift_data_out SHALL be sr[CFG_WIDTH-1] combinationally, so the chain delays data by exactly CFG_WIDTH accepted shifts.
REQ-017: Bit counter cnt SHALL increment on each accepted shift and saturate at CFG_WIDTH; further shifts keep shifting (chain pass-through).
REQ-018: States SHALL be derived from cnt: IDLE (cnt=0), SHIFTING (0<cnt<CFG_WIDTH), ARMED (cnt=CFG_WIDTH).
REQ-019: Priority per cycle SHALL be reset > restore > load > shift_valid; lower-priority requests in the same cycle are dropped, not deferred.
REQ-020: load in ARMED: gpio_config <= sr at that edge; load_done=1 the following cycle; cnt <= 0; sr unchanged.
REQ-021: load in IDLE or SHIFTING: gpio_config unchanged; load_error=1 the following cycle; cnt <= 0; sr unchanged.
REQ-022: restore: gpio_config <= gpio_defaults and sr <= gpio_defaults; cnt <= 0; no load_done or load_error pulse.
REQ-023: load_done and load_error SHALL be registered, mutually exclusive, and high for exactly one cycle per accepted load.
REQ-024: busy SHALL be registered as (cnt != 0) and is low in IDLE.
REQ-025: gpio_config SHALL change only on reset, restore, or a successful load.
REQ-026: shift_data and load SHALL be ignored when their qualifier (shift_valid, load) is low.

Reset
REQ-027: While reset is high at a clock edge, the block SHALL set gpio_config <= gpio_defaults, sr <= gpio_defaults, cnt <= 0, load_done=0, load_error=0, busy=0.
REQ-028: Reset asserted mid-shift SHALL discard all partial shift progress; the first load after reset without CFG_WIDTH shifts SHALL produce load_error.

Verification
REQ-029: gpio_defaults=10'h007, reset 2 cycles -> gpio_config=10'h007, shift_data_out=0, busy=0, no pulses.
REQ-030: 10 shifts of 10'h3A5 MSB-first, then load -> gpio_config=10'h3A5 the cycle after load, load_done one cycle, busy=0.
REQ-031: 4 shifts then load -> load_error one cycle, gpio_config stays 10'h007, busy=0.
REQ-032: 25 shifts of pattern P -> shift_data_out reproduces P delayed by 10 shifts; then load -> gpio_config = last 10 bits of P.
REQ-033: 10 shifts, then restore and load in the same cycle -> gpio_config=10'h007, sr=10'h007, no load_done, no load_error.
REQ-034: 6 shifts, reset 1 cycle, then load -> gpio_config=10'h007, load_error one cycle.
